// File: rtl/trace_cmp_pkg.sv
// Shared types for the lockstep trace comparator.
// Optional build macro: TRACE_CMP_MASK_EN (masked compare).
package trace_cmp_pkg;

    localparam int TRACE_W_DEF = 36;

    typedef logic [TRACE_W_DEF-1:0] trace_word_t;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_PASS,
        ST_FAIL
    } cmp_state_t;

    // Saturating increment for the 32-bit pair counter.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/trace_cmp_fifo.sv
// Trace FIFO: synchronous write, combinational head.
// A push into a full FIFO is dropped unless a pop frees a slot.
module trace_cmp_fifo
    import trace_cmp_pkg::*;
#(
    parameter int WIDTH = TRACE_W_DEF,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic             drop
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign drop  = push && full && !rd_en;
    assign head  = mem[rd_ptr[AW-1:0]];

    // Storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // Pointer update.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/trace_lockstep_cmp.sv
// In-order comparison of reference and optimised retire traces.
// Optional build macro: TRACE_CMP_MASK_EN ignores CMP_MASK bits.
module trace_lockstep_cmp
    import trace_cmp_pkg::*;
#(
    parameter int                 TRACE_W  = TRACE_W_DEF,
    parameter int                 DEPTH    = 16,
    parameter logic [TRACE_W-1:0] CMP_MASK = '0
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               a_valid,
    input  logic [TRACE_W-1:0] a_data,
    input  logic               a_trap,
    input  logic               b_valid,
    input  logic [TRACE_W-1:0] b_data,
    input  logic               b_trap,
    output logic               done,
    output logic               pass,
    output logic               mismatch,
    output logic               overflow,
    output logic               len_mismatch,
    output logic [31:0]        match_count,
    output logic [31:0]        err_index,
    output logic [TRACE_W-1:0] err_data_a,
    output logic [TRACE_W-1:0] err_data_b
);

`ifdef TRACE_CMP_MASK_EN
    localparam logic [TRACE_W-1:0] EFF_MASK = CMP_MASK;
`else
    // Masking disabled: every bit takes part in the compare.
    localparam logic [TRACE_W-1:0] EFF_MASK = CMP_MASK & {TRACE_W{1'b0}};
`endif

    cmp_state_t         state;
    cmp_state_t         state_nx;
    logic               active;
    logic               a_push;
    logic               b_push;
    logic               a_empty;
    logic               b_empty;
    logic               a_full;
    logic               b_full;
    logic               a_drop;
    logic               b_drop;
    logic [TRACE_W-1:0] a_head;
    logic [TRACE_W-1:0] b_head;
    logic               do_cmp;
    logic               words_eq;
    logic               ovf_evt;
    logic               set_mm;
    logic               set_len;

    assign active   = (state == ST_RUN) || (state == ST_DRAIN);
    assign a_push   = a_valid && active;
    assign b_push   = b_valid && active;
    assign do_cmp   = active && !a_empty && !b_empty;
    assign words_eq = ((a_head ^ b_head) & ~EFF_MASK) == '0;
    assign ovf_evt  = a_drop || b_drop;
    assign done     = (state == ST_PASS) || (state == ST_FAIL);
    assign pass     = (state == ST_PASS);

    trace_cmp_fifo #(
        .WIDTH (TRACE_W),
        .DEPTH (DEPTH)
    ) u_fifo_a (
        .clk    (clk),
        .resetn (resetn),
        .push   (a_push),
        .din    (a_data),
        .pop    (do_cmp),
        .head   (a_head),
        .full   (a_full),
        .empty  (a_empty),
        .drop   (a_drop)
    );

    trace_cmp_fifo #(
        .WIDTH (TRACE_W),
        .DEPTH (DEPTH)
    ) u_fifo_b (
        .clk    (clk),
        .resetn (resetn),
        .push   (b_push),
        .din    (b_data),
        .pop    (do_cmp),
        .head   (b_head),
        .full   (b_full),
        .empty  (b_empty),
        .drop   (b_drop)
    );

    // Next state and error events; overflow always wins into FAIL.
    always_comb begin
        state_nx = state;
        set_mm   = 1'b0;
        set_len  = 1'b0;
        case (state)
            ST_RUN: begin
                if (do_cmp && !words_eq) begin
                    set_mm   = 1'b1;
                    state_nx = ST_FAIL;
                end else if (a_trap && b_trap) begin
                    state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (do_cmp && !words_eq) begin
                    set_mm   = 1'b1;
                    state_nx = ST_FAIL;
                end else if (a_empty && b_empty) begin
                    state_nx = ST_PASS;
                end else if ((a_empty && !b_empty && !a_valid) ||
                             (b_empty && !a_empty && !b_valid)) begin
                    set_len  = 1'b1;
                    state_nx = ST_FAIL;
                end
            end
            default: begin
                state_nx = state;
            end
        endcase
        if (active && ovf_evt) begin
            state_nx = ST_FAIL;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_RUN;
        end else begin
            state <= state_nx;
        end
    end

    // Counters, sticky flags and first-error capture.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mismatch     <= 1'b0;
            overflow     <= 1'b0;
            len_mismatch <= 1'b0;
            match_count  <= '0;
            err_index    <= '0;
            err_data_a   <= '0;
            err_data_b   <= '0;
        end else if (active) begin
            if (do_cmp && words_eq) begin
                match_count <= sat_inc32(match_count);
            end
            if (ovf_evt) begin
                overflow <= 1'b1;
            end
            if (set_mm) begin
                mismatch   <= 1'b1;
                err_index  <= match_count;
                err_data_a <= a_head;
                err_data_b <= b_head;
            end
            if (set_len) begin
                len_mismatch <= 1'b1;
                err_index    <= match_count;
            end
        end
    end

endmodule

// File: tb/tb_trace_lockstep_cmp.sv
// Scoreboard bench for trace_lockstep_cmp.
// Masked-compare case runs only when TRACE_CMP_MASK_EN is defined.
module tb_trace_lockstep_cmp;
    import trace_cmp_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        a_valid;
    trace_word_t a_data;
    logic        a_trap;
    logic        b_valid;
    trace_word_t b_data;
    logic        b_trap;
    logic        done;
    logic        pass;
    logic        mismatch;
    logic        overflow;
    logic        len_mismatch;
    logic [31:0] match_count;
    logic [31:0] err_index;
    trace_word_t err_data_a;
    trace_word_t err_data_b;

    typedef struct {
        logic        pass_f;
        logic        mism;
        logic        ovf;
        logic        lenm;
        logic [31:0] mc;
        logic [31:0] ei;
        trace_word_t ea;
        trace_word_t eb;
    } exp_t;

    exp_t        sb[$];
    trace_word_t qa[$];
    trace_word_t qb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic        seen = 1'b0;

    always #5 clk = ~clk;

    trace_lockstep_cmp #(
        .TRACE_W  (36),
        .DEPTH    (16),
        .CMP_MASK (36'hF_0000_0000)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .a_valid      (a_valid),
        .a_data       (a_data),
        .a_trap       (a_trap),
        .b_valid      (b_valid),
        .b_data       (b_data),
        .b_trap       (b_trap),
        .done         (done),
        .pass         (pass),
        .mismatch     (mismatch),
        .overflow     (overflow),
        .len_mismatch (len_mismatch),
        .match_count  (match_count),
        .err_index    (err_index),
        .err_data_a   (err_data_a),
        .err_data_b   (err_data_b)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic p, input logic mm,
                                input logic ov, input logic lm,
                                input logic [31:0] mc,
                                input logic [31:0] ei,
                                input trace_word_t ea,
                                input trace_word_t eb);
        exp_t e;
        e.pass_f = p;
        e.mism   = mm;
        e.ovf    = ov;
        e.lenm   = lm;
        e.mc     = mc;
        e.ei     = ei;
        e.ea     = ea;
        e.eb     = eb;
        return e;
    endfunction

    // Monitor: on each rise of done, pop the expected result and compare.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!done) begin
            seen = 1'b0;
        end else if (!seen) begin
            seen = 1'b1;
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done=1, expected none");
            end else begin
                e = sb.pop_front();
                chk("pass", pass, e.pass_f);
                chk("mismatch", mismatch, e.mism);
                chk("overflow", overflow, e.ovf);
                chk("len_mismatch", len_mismatch, e.lenm);
                chk("match_count", match_count, e.mc);
                chk("err_index", err_index, e.ei);
                chk("err_data_a", err_data_a, e.ea);
                chk("err_data_b", err_data_b, e.eb);
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_mismatch"}, mismatch, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_len"}, len_mismatch, 0);
        chk({tag, "_mc"}, match_count, 0);
        chk({tag, "_ei"}, err_index, 0);
        chk({tag, "_eda"}, err_data_a, 0);
        chk({tag, "_edb"}, err_data_b, 0);
    endtask

    task automatic do_reset();
        #1;
        resetn  = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_data  = '0;
        b_data  = '0;
        a_trap  = 1'b0;
        b_trap  = 1'b0;
        #2;
        chk_zero("rst");
        repeat (2) @(posedge clk);
        #3;
        resetn = 1'b1;
    endtask

    // Drive qa from cycle 0 and qb from cycle bdly, one word per cycle.
    task automatic drive(input int bdly);
        int n;
        int bi;
        n = qa.size();
        if (qb.size() + bdly > n) n = qb.size() + bdly;
        for (int t = 0; t < n; t++) begin
            @(posedge clk);
            #1;
            a_valid = (t < qa.size());
            a_data  = a_valid ? qa[t] : '0;
            bi      = t - bdly;
            b_valid = (bi >= 0) && (bi < qb.size());
            b_data  = b_valid ? qb[bi] : '0;
        end
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic trap_both();
        repeat (2) @(posedge clk);
        #1;
        a_trap = 1'b1;
        b_trap = 1'b1;
    endtask

    task automatic wait_done(input string nm);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got done=0, expected done=1", nm);
            if (sb.size() > 0) void'(sb.pop_front());
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        do_reset();

        // Identical streams, B three cycles late.
        qa = {36'h1, 36'h2, 36'h3, 36'h4, 36'h5};
        qb = qa;
        sb.push_back(mk(1, 0, 0, 0, 5, 0, 0, 0));
        drive(3);
        trap_both();
        wait_done("t1");
        do_reset();

        // Third word differs.
        qa = {36'h1, 36'h2, 36'hA3, 36'h4, 36'h5};
        qb = {36'h1, 36'h2, 36'hB3, 36'h4, 36'h5};
        sb.push_back(mk(0, 1, 0, 0, 2, 2, 36'hA3, 36'hB3));
        drive(0);
        trap_both();
        wait_done("t2");
        do_reset();

        // 17 words into A while B is silent.
        qa.delete();
        for (int i = 0; i < 17; i++) qa.push_back(trace_word_t'(i + 1));
        qb.delete();
        sb.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0));
        drive(0);
        wait_done("t3");
        do_reset();

        // A has one more word than B.
        qa = {36'h11, 36'h12, 36'h13, 36'h14};
        qb = {36'h11, 36'h12, 36'h13};
        sb.push_back(mk(0, 0, 0, 1, 3, 3, 0, 0));
        drive(0);
        trap_both();
        wait_done("t4");
        do_reset();

        // Two matches, then asynchronous reset mid-stream.
        qa = {36'h21, 36'h22};
        qb = qa;
        drive(0);
        repeat (2) @(posedge clk);
        #1;
        chk("pre_reset_mc", match_count, 2);
        a_valid = 1'b1;
        a_data  = 36'h23;
        #1;
        resetn = 1'b0;
        #1;
        chk_zero("async");
        do_reset();
        qa = {36'h31, 36'h32, 36'h33};
        qb = qa;
        sb.push_back(mk(1, 0, 0, 0, 3, 0, 0, 0));
        drive(1);
        trap_both();
        wait_done("t5");
        do_reset();

`ifdef TRACE_CMP_MASK_EN
        // Words differ only in the masked top nibble.
        qa = {36'h0_0000_0010, 36'h0_0000_0011,
              36'h0_0000_0012, 36'h0_0000_0013};
        qb = {36'h1_0000_0010, 36'h2_0000_0011,
              36'h3_0000_0012, 36'h4_0000_0013};
        sb.push_back(mk(1, 0, 0, 0, 4, 0, 0, 0));
        drive(2);
        trap_both();
        wait_done("t6");
        do_reset();
`endif

        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL leftover: got %0d pending, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

endmodule
